// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter slice.
//   owner_e          : which requester currently drives the DATAMEM port
//   DMEM_AW/DMEM_DW  : DATAMEM address and data widths
//   ARB_MAX_WAIT_DEF : default bound on how long a debug request may be denied
package dmem_pkg;

  localparam int DMEM_AW          = 9;
  localparam int DMEM_DW          = 32;
  localparam int ARB_MAX_WAIT_DEF = 4;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, forces cnt to zero
//   inc   : advance by one unless already at LIMIT
//   clr   : return to zero (wins over inc)
//   cnt   : current count
module sat_counter #(
  parameter int             W     = 8,
  parameter logic [W-1:0]   LIMIT = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    if (v == LIMIT) begin
      return v;
    end
    return v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single DATAMEM port between the CPU core and a
// debug/loader port. The CPU has priority; a bounded wait counter forces a
// debug slot after MAX_WAIT denied cycles, and dbg_halt parks ownership on
// the debug side for bulk transfers.
//   clk, rst               : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata  : CPU access request (0-cycle when CPU owns the port)
//   cpu_rdata              : combinational read data straight from mem_dout
//   cpu_stall              : CPU must hold PC and suppress writeback
//   dbg_req/we/addr/wdata  : debug request, held until dbg_ack
//   dbg_halt               : level request to freeze the core
//   dbg_ack, dbg_rdata     : one-cycle completion pulse with registered read data
//   cpu_halted             : debug owns the port because of halt
//   stall_cnt              : saturating count of stalled CPU cycles
//   mem_wen/addr/din/dout  : DATAMEM port
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW       = DMEM_AW,
  parameter int DW       = DMEM_DW,
  parameter int MAX_WAIT = ARB_MAX_WAIT_DEF,
  parameter int SCW      = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cpu_req,
  input  logic           cpu_we,
  input  logic [AW-1:0]  cpu_addr,
  input  logic [DW-1:0]  cpu_wdata,
  output logic [DW-1:0]  cpu_rdata,
  output logic           cpu_stall,
  input  logic           dbg_req,
  input  logic           dbg_we,
  input  logic [AW-1:0]  dbg_addr,
  input  logic [DW-1:0]  dbg_wdata,
  input  logic           dbg_halt,
  output logic           dbg_ack,
  output logic [DW-1:0]  dbg_rdata,
  output logic           cpu_halted,
  output logic [SCW-1:0] stall_cnt,
  output logic           mem_wen,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_din,
  input  logic [DW-1:0]  mem_dout
);

  localparam int             WCW      = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LIM = WCW'(MAX_WAIT);

  owner_e         owner;
  owner_e         owner_nxt;
  logic           dbg_live;
  logic           dbg_access;
  logic           wait_full;
  logic           wait_inc;
  logic           wait_clr;
  logic [WCW-1:0] wait_cnt;

  // A request that is already being acknowledged must not be served again,
  // otherwise a requester holding dbg_req through the ack cycle would replay.
  assign dbg_live   = dbg_req & ~dbg_ack;
  assign dbg_access = (owner == OWN_DBG) & dbg_live;
  assign wait_full  = (wait_cnt == WAIT_LIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= OWN_CPU;
    end else begin
      owner <= owner_nxt;
    end
  end

  always_comb begin
    owner_nxt = owner;
    case (owner)
      OWN_CPU: begin
        if (dbg_halt || (dbg_live && (!cpu_req || wait_full))) begin
          owner_nxt = OWN_DBG;
        end
      end
      OWN_DBG: begin
        // Without halt the debug slot is a single cycle; an abandoned
        // request (dbg_req dropped) also hands the port back.
        if (!dbg_halt && (dbg_live || !dbg_req)) begin
          owner_nxt = OWN_CPU;
        end
      end
      default: owner_nxt = OWN_CPU;
    endcase
  end

  always_comb begin
    mem_addr = cpu_addr;
    mem_din  = cpu_wdata;
    mem_wen  = 1'b0;
    if (owner == OWN_DBG) begin
      mem_addr = dbg_addr;
      mem_din  = dbg_wdata;
      mem_wen  = dbg_live & dbg_we;
    end else begin
      mem_wen  = cpu_req & cpu_we;
    end
    // No write may land in a reset cycle, even if an access was in flight.
    if (rst) begin
      mem_wen = 1'b0;
    end
  end

  assign cpu_rdata  = mem_dout;
  assign cpu_stall  = cpu_req & (owner == OWN_DBG);
  assign cpu_halted = (owner == OWN_DBG) & dbg_halt;

  // Debug completion: ack and capture read data one edge after the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_ack   <= 1'b0;
      dbg_rdata <= '0;
    end else begin
      dbg_ack <= dbg_access;
      if (dbg_access && !dbg_we) begin
        dbg_rdata <= mem_dout;
      end
    end
  end

  assign wait_inc = (owner == OWN_CPU) & dbg_live & (owner_nxt == OWN_CPU);
  assign wait_clr = ((owner == OWN_CPU) & (owner_nxt == OWN_DBG)) | ~dbg_req;

  sat_counter #(
    .W     (WCW),
    .LIMIT (WAIT_LIM)
  ) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .inc (wait_inc),
    .clr (wait_clr),
    .cnt (wait_cnt)
  );

  sat_counter #(
    .W     (SCW),
    .LIMIT ({SCW{1'b1}})
  ) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cpu_stall),
    .clr (1'b0),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: behavioural DATAMEM, scoreboard of expected
// debug read-back values, reference memory image, and a stall-count model.
module tb_dmem_arbiter;

  localparam int AW  = 9;
  localparam int DW  = 32;
  localparam int MW  = 4;
  localparam int SCW = 16;

  logic           clk;
  logic           rst;
  logic           cpu_req;
  logic           cpu_we;
  logic [AW-1:0]  cpu_addr;
  logic [DW-1:0]  cpu_wdata;
  logic [DW-1:0]  cpu_rdata;
  logic           cpu_stall;
  logic           dbg_req;
  logic           dbg_we;
  logic [AW-1:0]  dbg_addr;
  logic [DW-1:0]  dbg_wdata;
  logic           dbg_halt;
  logic           dbg_ack;
  logic [DW-1:0]  dbg_rdata;
  logic           cpu_halted;
  logic [SCW-1:0] stall_cnt;
  logic           mem_wen;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_din;
  logic [DW-1:0]  mem_dout;

  dmem_arbiter #(
    .AW       (AW),
    .DW       (DW),
    .MAX_WAIT (MW),
    .SCW      (SCW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .dbg_req    (dbg_req),
    .dbg_we     (dbg_we),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .dbg_halt   (dbg_halt),
    .dbg_ack    (dbg_ack),
    .dbg_rdata  (dbg_rdata),
    .cpu_halted (cpu_halted),
    .stall_cnt  (stall_cnt),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural DATAMEM: synchronous write, combinational read.
  logic          mem_init;
  logic [DW-1:0] mem     [0:511];
  logic [DW-1:0] ref_mem [0:511];

  assign mem_dout = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= '0;
    end else if (mem_wen) begin
      mem[mem_addr] <= mem_din;
    end
  end

  int            total;
  int            bad;
  int            wen_cnt;
  int            exp_stall;
  logic          mon_on;
  logic          halt_watch;
  logic [DW-1:0] exp_last_rd;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Monitor: scoreboard pops on each ack, CPU reads against the reference
  // image, and the stall counter against a count of observed stall cycles.
  always @(negedge clk) begin
    if (mon_on) begin
      if (!rst) begin
        if (dbg_ack) begin
          if (exp_q.size() == 0) begin
            chk("dbg_ack_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("dbg_rdata", dbg_rdata, e);
          end
        end
        if (mem_wen) wen_cnt++;
        if (cpu_req && !cpu_stall) begin
          if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
          else        chk("cpu_rdata", cpu_rdata, ref_mem[cpu_addr]);
        end
        if (halt_watch) begin
          chk("halt_cpu_stall", {31'd0, cpu_stall}, 32'd1);
          chk("halt_cpu_halted", {31'd0, cpu_halted}, 32'd1);
        end
      end
      chk("stall_cnt", {16'd0, stall_cnt}, exp_stall);
      if (rst)                        exp_stall = 0;
      else if (exp_stall < 65535)     exp_stall = exp_stall + int'(cpu_stall);
    end
  end

  task automatic push_expect(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (we) begin
      ref_mem[a] = d;
    end else begin
      exp_last_rd = ref_mem[a];
    end
    exp_q.push_back(exp_last_rd);
  endtask

  // One debug transfer; returns the number of edges from request to ack.
  task automatic dbg_xfer(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int lat);
    push_expect(we, a, d);
    dbg_we    = we;
    dbg_addr  = a;
    dbg_wdata = d;
    dbg_req   = 1'b1;
    lat       = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!dbg_ack && lat < 20);
    chk("dbg_ack_seen", {31'd0, dbg_ack}, 32'd1);
    if (!dbg_ack) exp_q.delete(exp_q.size() - 1);
    dbg_req = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  int lat;
  int pend;
  int gap;
  int mm;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0; wen_cnt = 0; exp_stall = 0;
    mon_on = 1'b0; halt_watch = 1'b0; exp_last_rd = '0;
    for (int i = 0; i < 512; i++) ref_mem[i] = '0;
    mem_init  = 1'b1;
    rst       = 1'b1;
    cpu_req   = 1'b0; cpu_we = 1'b0; cpu_addr = 9'h1AB; cpu_wdata = '0;
    dbg_req   = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h005; dbg_wdata = 32'h55AA55AA;
    dbg_halt  = 1'b0;

    // Reset with a debug write pending
    repeat (2) begin
      @(negedge clk);
      chk("rst_mem_wen", {31'd0, mem_wen}, 32'd0);
    end
    chk("rst_dbg_ack", {31'd0, dbg_ack}, 32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_owner_cpu_addr", {23'd0, mem_addr}, 32'h1AB);
    chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; dbg_req = 1'b0; mem_init = 1'b0;
    exp_stall = 0; mon_on = 1'b1;
    idle(1);

    // Uncontended write then read
    dbg_xfer(1'b1, 9'h010, 32'hDEADBEEF, lat);
    chk("unc_wr_lat", lat, 32'd2);
    idle(1);
    dbg_xfer(1'b0, 9'h010, '0, lat);
    chk("unc_rd_lat", lat, 32'd2);
    chk("unc_rd_data", dbg_rdata, 32'hDEADBEEF);
    chk("unc_no_stall", {16'd0, stall_cnt}, 32'd0);
    idle(1);

    // Contention: CPU busy every cycle
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h000;
    idle(1);
    dbg_xfer(1'b0, 9'h010, '0, lat);
    chk("cont_lat", lat, MW + 2);
    chk("cont_rd_data", dbg_rdata, 32'hDEADBEEF);
    chk("cont_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    idle(1);

    // Halt burst
    dbg_halt = 1'b1;
    idle(1);
    halt_watch = 1'b1;
    dbg_xfer(1'b1, 9'h000, 32'hA0A0A0A0, lat);
    chk("halt_lat0", lat, 32'd1);
    dbg_xfer(1'b1, 9'h001, 32'hA1A1A1A1, lat);
    chk("halt_lat1", lat, 32'd2);
    dbg_xfer(1'b1, 9'h002, 32'hA2A2A2A2, lat);
    chk("halt_lat2", lat, 32'd2);
    halt_watch = 1'b0;
    dbg_halt = 1'b0;
    cpu_addr = 9'h002;
    idle(1);
    chk("post_halt_stall", {31'd0, cpu_stall}, 32'd0);
    chk("post_halt_cpu_rd", cpu_rdata, 32'hA2A2A2A2);
    cpu_req = 1'b0;
    idle(1);

    // Request held through its ack cycle: exactly one write, one ack
    wen_cnt = 0;
    push_expect(1'b1, 9'h020, 32'h0BADF00D);
    dbg_we = 1'b1; dbg_addr = 9'h020; dbg_wdata = 32'h0BADF00D; dbg_req = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!dbg_ack && lat < 20);
    chk("hold_ack_seen", {31'd0, dbg_ack}, 32'd1);
    @(posedge clk); #1;
    dbg_req = 1'b0;
    chk("hold_ack_single", {31'd0, dbg_ack}, 32'd0);
    idle(2);
    chk("hold_wen_once", wen_cnt, 32'd1);

    // Reset during a halted debug write
    dbg_halt = 1'b1;
    idle(1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h100;
    dbg_we = 1'b1; dbg_addr = 9'h030; dbg_wdata = 32'hCAFEF00D; dbg_req = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_halt_wen", {31'd0, mem_wen}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; dbg_req = 1'b0; dbg_halt = 1'b0;
    exp_last_rd = '0;
    chk("rst_halt_owner", {31'd0, cpu_stall}, 32'd0);
    chk("rst_halt_ack", {31'd0, dbg_ack}, 32'd0);
    chk("rst_halt_halted", {31'd0, cpu_halted}, 32'd0);
    idle(1);

    // Randomized traffic: CPU in the upper half, debug in the lower half
    pend = 0; gap = 1;
    for (int c = 0; c < 3000; c++) begin
      cpu_req   = ($urandom % 10) < 6;
      cpu_we    = $urandom % 2;
      cpu_addr  = {1'b1, 8'($urandom)};
      cpu_wdata = $urandom;
      if (pend == 0) begin
        if ($urandom % 64 == 0) dbg_halt = ~dbg_halt;
        if (gap > 0) begin
          gap--;
        end else if ($urandom % 3 == 0) begin
          dbg_we    = $urandom % 2;
          dbg_addr  = {5'd0, 4'($urandom)};
          dbg_wdata = $urandom;
          push_expect(dbg_we, dbg_addr, dbg_wdata);
          dbg_req = 1'b1;
          lat = 0;
          pend = 1;
        end
      end
      @(posedge clk); #1;
      if (pend != 0) begin
        lat++;
        if (dbg_ack) begin
          chk("rnd_lat_bound", {31'd0, lat <= MW + 2}, 32'd1);
          dbg_req = 1'b0;
          pend = 0;
          gap = 1 + $urandom % 3;
        end else if (lat >= 20) begin
          chk("rnd_ack_timeout", {31'd0, dbg_ack}, 32'd1);
          exp_q.delete(exp_q.size() - 1);
          dbg_req = 1'b0;
          pend = 0;
          gap = 1;
        end
      end
    end

    dbg_halt = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
    idle(3);
    chk("sb_empty", exp_q.size(), 32'd0);
    mm = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) mm++;
    chk("mem_image_diffs", mm, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
